// File: rtl/aes_round_sequencer.sv
// AES round sequencer: owns the cipher state register, the round counter and
// round-key selection for AES-128/192/256. It drives an external
// combinational round datapath one round per enabled clock, and can run the
// inverse cipher on its own ciphertext to confirm a round trip.
module aes_round_sequencer #(
    parameter int NR_MAX = 14,
    parameter int DATA_W = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [1:0]                   op,
    input  logic                         step_en,
    input  logic [DATA_W-1:0]            data_in,
    input  logic [(NR_MAX+1)*DATA_W-1:0] expansion,
    output logic [DATA_W-1:0]            rnd_state,
    output logic [DATA_W-1:0]            rk,
    output logic [1:0]                   rnd_type,
    output logic                         rnd_dir,
    input  logic [DATA_W-1:0]            rnd_result,
    output logic                         busy,
    output logic                         cipher_valid,
    output logic [DATA_W-1:0]            cipher_out,
    output logic                         plain_valid,
    output logic [DATA_W-1:0]            plain_out,
    output logic                         match,
    output logic                         err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_DEC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Pick round key idx out of the flattened expansion bus; indices past
    // NR_MAX never occur but resolve to zero rather than out-of-range.
    function automatic logic [DATA_W-1:0] key_slice(
        input logic [(NR_MAX+1)*DATA_W-1:0] exp_bus,
        input logic [3:0]                   idx
    );
        logic [DATA_W-1:0] sel;
        sel = '0;
        for (int r = 0; r <= NR_MAX; r++) begin
            if (idx == 4'(r)) begin
                sel = exp_bus[DATA_W*r +: DATA_W];
            end
        end
        return sel;
    endfunction

    state_t            r_fsm;
    state_t            w_fsm_nxt;
    logic [3:0]        r_round;
    logic [3:0]        r_nr;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_plain;
    logic [DATA_W-1:0] r_state;
    logic [DATA_W-1:0] r_cipher_out;
    logic [DATA_W-1:0] r_plain_out;
    logic              r_cipher_valid;
    logic              r_plain_valid;
    logic              r_match;
    logic              r_err;

    logic              w_can_start;
    logic              w_legal;
    logic              w_accept;
    logic              w_illegal;
    logic [3:0]        w_nr_req;
    logic              w_active;
    logic [DATA_W-1:0] w_rk_cur;
    logic [DATA_W-1:0] w_rk_zero;
    logic [DATA_W-1:0] w_rk_nr;
    logic [DATA_W-1:0] w_rk_nr_req;

    // Start qualification, requested round count and round-key taps.
    always_comb begin
        w_can_start = (r_fsm == ST_IDLE) || (r_fsm == ST_DONE);
        w_legal     = (mode != 2'b11) && (op != 2'b11);
        w_accept    = start && w_can_start && w_legal;
        w_illegal   = start && w_can_start && !w_legal;
        w_active    = (r_fsm == ST_ENC) || (r_fsm == ST_DEC);
        case (mode)
            2'b00:   w_nr_req = 4'd10;
            2'b01:   w_nr_req = 4'd12;
            2'b10:   w_nr_req = 4'd14;
            default: w_nr_req = 4'd10;
        endcase
        w_rk_cur    = key_slice(expansion, r_round);
        w_rk_zero   = key_slice(expansion, 4'd0);
        w_rk_nr     = key_slice(expansion, r_nr);
        w_rk_nr_req = key_slice(expansion, w_nr_req);
    end

    // Next-state decode; a start arriving while ENC/DEC is simply ignored.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_fsm_nxt = (op == 2'b01) ? ST_DEC : ST_ENC;
                end else begin
                    w_fsm_nxt = r_fsm;
                end
            end
            ST_ENC: begin
                if (step_en && (r_round == r_nr)) begin
                    w_fsm_nxt = (r_op == 2'b10) ? ST_DEC : ST_DONE;
                end else begin
                    w_fsm_nxt = r_fsm;
                end
            end
            ST_DEC: begin
                if (step_en && (r_round == 4'd0)) begin
                    w_fsm_nxt = ST_DONE;
                end else begin
                    w_fsm_nxt = r_fsm;
                end
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Cipher state, round counter, captured request and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_round        <= 4'd0;
            r_nr           <= 4'd0;
            r_op           <= 2'b00;
            r_plain        <= '0;
            r_state        <= '0;
            r_cipher_out   <= '0;
            r_plain_out    <= '0;
            r_cipher_valid <= 1'b0;
            r_plain_valid  <= 1'b0;
            r_match        <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_cipher_valid <= 1'b0;
            r_plain_valid  <= 1'b0;
            r_err          <= w_illegal;
            case (r_fsm)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_nr    <= w_nr_req;
                        r_op    <= op;
                        r_plain <= data_in;
                        r_match <= 1'b0;
                        if (op == 2'b01) begin
                            r_state <= data_in ^ w_rk_nr_req;
                            r_round <= w_nr_req - 4'd1;
                        end else begin
                            r_state <= data_in ^ w_rk_zero;
                            r_round <= 4'd1;
                        end
                    end
                end
                ST_ENC: begin
                    if (step_en) begin
                        if (r_round == r_nr) begin
                            r_cipher_out   <= rnd_result;
                            r_cipher_valid <= 1'b1;
                            if (r_op == 2'b10) begin
                                // Round trip: begin the inverse cipher at once.
                                r_state <= rnd_result ^ w_rk_nr;
                                r_round <= r_nr - 4'd1;
                            end else begin
                                r_state <= rnd_result;
                            end
                        end else begin
                            r_state <= rnd_result;
                            r_round <= r_round + 4'd1;
                        end
                    end
                end
                ST_DEC: begin
                    if (step_en) begin
                        r_state <= rnd_result;
                        if (r_round == 4'd0) begin
                            r_plain_out   <= rnd_result;
                            r_plain_valid <= 1'b1;
                            r_match       <= (r_op == 2'b10) && (rnd_result == r_plain);
                        end else begin
                            r_round <= r_round - 4'd1;
                        end
                    end
                end
                default: begin
                    r_round <= r_round;
                end
            endcase
        end
    end

    // Datapath drive and status decoded from the registered FSM state.
    always_comb begin
        rnd_state    = r_state;
        busy         = w_active;
        rk           = w_active ? w_rk_cur : w_rk_zero;
        rnd_dir      = (r_fsm == ST_DEC);
        case (r_fsm)
            ST_ENC:  rnd_type = (r_round == r_nr) ? 2'b10 : 2'b01;
            ST_DEC:  rnd_type = (r_round == 4'd0) ? 2'b10 : 2'b01;
            default: rnd_type = 2'b00;
        endcase
        cipher_valid = r_cipher_valid;
        cipher_out   = r_cipher_out;
        plain_valid  = r_plain_valid;
        plain_out    = r_plain_out;
        match        = r_match;
        err          = r_err;
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Runtime-configurable AES round sequencer that replaces the fixed per-key-size encrypt/decrypt instances and step counter of the board-level AES demo. It owns the 128-bit state register, the round counter and the key-slice selection for AES-128/192/256. It drives an external combinational round datapath one round per enabled clock and optionally runs the inverse cipher on its own ciphertext, flagging a round-trip match.

## Interface
- NR_MAX, 14, highest round count supported; sizes the expansion bus.
- DATA_W, 128, state and round-key width; fixed at 128 for AES.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE or DONE.
- mode  in  2  key size: 00 AES-128 (Nr=10), 01 AES-192 (Nr=12), 10 AES-256 (Nr=14), 11 illegal.
- op  in  2  00 encrypt, 01 decrypt (data_in is ciphertext), 10 encrypt then decrypt (round trip), 11 illegal.
- step_en  in  1  advance one round when high; hold when low.
- data_in  in  DATA_W  plaintext or ciphertext; sampled on start acceptance.
- expansion  in  (NR_MAX+1)*DATA_W  round keys; rk[r] = expansion[DATA_W*r +: DATA_W]; slices above Nr unused.
- rnd_state  out  DATA_W  current state to datapath.
- rk  out  DATA_W  round key for current round.
- rnd_type  out  2  00 none, 01 middle round, 10 final round.
- rnd_dir  out  1  0 forward cipher, 1 inverse cipher.
- rnd_result  in  DATA_W  datapath output for (rnd_state, rk, rnd_type, rnd_dir).
- busy  out  1  high in ENC or DEC.
- cipher_valid  out  1  one-cycle pulse; cipher_out updated.
- cipher_out  out  DATA_W  last ciphertext.
- plain_valid  out  1  one-cycle pulse; plain_out updated.
- plain_out  out  DATA_W  last decrypted text.
- match  out  1  round-trip result equals captured plaintext; valid from plain_valid until next accepted start.
- err  out  1  one-cycle pulse on start with illegal mode or op.

## Operation
- States: IDLE, ENC, DEC, DONE. Reset -> IDLE; all outputs, state, round counter, captured mode/op and stored plaintext cleared to 0.
- Start acceptance (IDLE/DONE, legal mode/op): latch Nr, op, data_in (stored plaintext). Same edge clears match and loads the state register:
  - op 00/10: state <= data_in ^ rk[0], round <= 1, -> ENC.
  - op 01: state <= data_in ^ rk[Nr], round <= Nr-1, -> DEC.
- Illegal start: err pulses, FSM, state and match unchanged. Start in ENC/DEC: ignored, no err. mode/op/data_in changes after acceptance are ignored.
- ENC: rnd_dir=0, rk=rk[round]; rnd_type=10 when round==Nr, else 01. On edge with step_en=1: state <= rnd_result, round++.
  - When round==Nr: cipher_out <= rnd_result, cipher_valid pulses. Op 00 -> DONE. Op 10 -> DEC with state <= rnd_result ^ rk[Nr], round <= Nr-1.
- DEC: rnd_dir=1, rk=rk[round]; rnd_type=10 when round==0, else 01. On step: state <= rnd_result, round--.
  - When round==0: plain_out <= rnd_result, plain_valid pulses, -> DONE. Match <= (rnd_result == stored plaintext) only for op 10; stays 0 for op 01.
- IDLE/DONE: rnd_type=00, rnd_dir=0, rk=rk[0]; cipher_out/plain_out hold.
- step_en=0: all registers hold; rnd_* outputs stay stable.

## Timing
- Start accepted at edge k with step_en held high: cipher_valid high in cycle after edge k+Nr (op 00/10). plain_valid high after edge k+2Nr (op 10) or k+Nr (op 01).
- Each low step_en cycle delays all subsequent events by one cycle.
- busy rises the cycle after acceptance; falls with the final valid pulse (DONE entered on the same edge).
- Start on the same edge as DONE entry is not accepted (FSM still ENC/DEC); start one cycle later is.
- reset mid-operation: immediate return to IDLE, no valid pulse, outputs 0.
- Round counter is 4 bits; never wraps: ENC stops at Nr, DEC stops at 0.

## Test plan
- Stub datapath rnd_result = rnd_state ^ rk, rk[r] = 128'(r), data_in = 128'h00112233445566778899aabbccddeeff. AES-128 op 10, step_en=1 -> cipher_out = data_in ^ 128'hB after 10 cycles, plain_out = data_in after 20, match=1.
- Same stub, AES-192 and AES-256 op 00 -> cipher_out = data_in ^ 128'hC at cycle 12, data_in ^ 128'hF at cycle 14; rnd_type=10 only on final round.
- Op 01, AES-128, data_in = cipher from test 1 -> plain_valid after 10 cycles, plain_out = original plaintext, match=0.
- step_en toggled 1,0 every cycle, AES-128 op 00 -> cipher_valid at cycle 20; start during ENC ignored; mode=11 start -> err pulse, stays IDLE.
- reset asserted at round 5 of AES-256 -> busy, outputs, match all 0 asynchronously; new start afterwards completes normally.
- Real AES round datapath, AES-128 key 000102..0f, op 10 -> cipher_out = 128'h69c4e0d86a7b0430d8cdb78070b4c55a, match=1.
